// File: rtl/flash_cfg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flash_cfg_ctrl
// Purpose  : Parallel-NOR flash controller. After reset it reads NUM_CFG
//            32-bit configuration words from CFG_BASE and presents them as
//            static outputs. It then serves slow-control flash read/write
//            and control requests (FPGA reload, boot re-run). Bus timing is
//            set by parameters.
// Ports    : clk, reset (async, active high)
//            fpga_reload         - reload request, rising edge triggers
//            sc_*                - slow-control request / reply handshake
//            cfg_words/cfg_valid - boot configuration words
//            flash_*             - flash pins towards the top-level IOBUFs
//            prog_b_drive        - 1 drives FPGA_PROG_B low
// Revision : 1.0 - initial release
// ============================================================================
module flash_cfg_ctrl #(
  parameter int              ADDR_W      = 24,
  parameter int              DQ_W        = 16,
  parameter int              NUM_CFG     = 2,
  parameter logic [ADDR_W-1:0] CFG_BASE  = 24'h7F0000,
  parameter int              RD_CYCLES   = 8,
  parameter int              WR_CYCLES   = 8,
  parameter int              TURN_CYCLES = 2,
  parameter int              PROG_PULSE  = 16,
  parameter logic [15:0]     SC_PORT     = 16'h2777
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fpga_reload,
  input  logic [15:0]             sc_port,
  input  logic [31:0]             sc_data,
  input  logic [31:0]             sc_addr,
  input  logic [31:0]             sc_subaddr,
  input  logic                    sc_op,
  input  logic                    sc_wr,
  input  logic                    sc_frame,
  output logic                    sc_ack,
  output logic [31:0]             sc_rply_data,
  output logic [31:0]             sc_rply_error,
  output logic [32*NUM_CFG-1:0]   cfg_words,
  output logic                    cfg_valid,
  output logic [ADDR_W-1:0]       flash_a,
  output logic [DQ_W-1:0]         flash_dq_o,
  input  logic [DQ_W-1:0]         flash_dq_i,
  output logic                    flash_dq_t,
  output logic                    flash_cs_b,
  output logic                    flash_oe_b,
  output logic                    flash_we_b,
  output logic                    prog_b_drive
);

  localparam int NB    = 32 / DQ_W;
  localparam int CNT_W = 16;

  // Counter terminal values; TURN_CYCLES/PROG_PULSE below 1 behave as 1.
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_HOLD   = CNT_W'(WR_CYCLES);
  localparam logic [CNT_W-1:0] WR_END    = CNT_W'(WR_CYCLES + 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN_CYCLES > 1) ? TURN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'((PROG_PULSE > 1) ? PROG_PULSE - 1 : 0);
  localparam logic [1:0]       LAST_WORD = 2'(NB - 1);
  localparam logic [2:0]       LAST_CFG  = 3'(NUM_CFG - 1);

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_RD     = 3'd2,
    ST_WR     = 3'd3,
    ST_TURN   = 3'd4,
    ST_ACK    = 3'd5,
    ST_RELOAD = 3'd6
  } state_t;

  // What the current bus sequence is for; decides the action after TURN.
  typedef enum logic [1:0] {
    K_BOOT    = 2'd0,
    K_BOOT_SC = 2'd1,
    K_READ    = 2'd2,
    K_WRITE   = 2'd3
  } kind_t;

  state_t state, state_n;
  kind_t  kind, kind_n;

  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [1:0]             word_idx, word_idx_n;
  logic [2:0]             cfg_idx, cfg_idx_n;
  logic [31:0]            asm_word, asm_word_n;
  logic [32*NUM_CFG-1:0]  cfg_shadow, cfg_shadow_n, merged;
  logic                   ack_reload, ack_reload_n;
  logic                   reload_q, reload_pend, reload_pend_n;
  logic                   hold_off, hold_off_n;

  logic [ADDR_W-1:0]      flash_a_n;
  logic [DQ_W-1:0]        flash_dq_o_n;
  logic                   flash_dq_t_n, flash_cs_b_n, flash_oe_b_n, flash_we_b_n;
  logic                   sc_ack_n, cfg_valid_n, prog_b_drive_n;
  logic [31:0]            sc_rply_data_n, sc_rply_error_n;
  logic [32*NUM_CFG-1:0]  cfg_words_n;

  // Shared actions requested from several states.
  logic                   launch_rd;
  logic [ADDR_W-1:0]      launch_addr;
  logic                   do_ack;
  logic [31:0]            ack_data, ack_err;

  logic                   addr_hi_bad;
  logic                   unused_sc_data;

  assign addr_hi_bad    = (sc_addr >> ADDR_W) != 32'd0;
  assign unused_sc_data = ^sc_data;

  always_comb begin
    state_n         = state;
    kind_n          = kind;
    cnt_n           = cnt;
    word_idx_n      = word_idx;
    cfg_idx_n       = cfg_idx;
    asm_word_n      = asm_word;
    cfg_shadow_n    = cfg_shadow;
    ack_reload_n    = ack_reload;
    reload_pend_n   = reload_pend;
    hold_off_n      = 1'b0;
    flash_a_n       = flash_a;
    flash_dq_o_n    = flash_dq_o;
    flash_dq_t_n    = flash_dq_t;
    flash_cs_b_n    = flash_cs_b;
    flash_oe_b_n    = flash_oe_b;
    flash_we_b_n    = flash_we_b;
    sc_ack_n        = 1'b0;
    sc_rply_data_n  = sc_rply_data;
    sc_rply_error_n = sc_rply_error;
    cfg_words_n     = cfg_words;
    cfg_valid_n     = cfg_valid;
    prog_b_drive_n  = prog_b_drive;
    launch_rd       = 1'b0;
    launch_addr     = flash_a;
    do_ack          = 1'b0;
    ack_data        = 32'd0;
    ack_err         = 32'd0;

    // Shadow copy with the word just assembled dropped into its slot.
    merged = cfg_shadow;
    merged[32*int'(cfg_idx) +: 32] = asm_word;

    case (state)
      ST_BOOT: begin
        word_idx_n  = 2'd0;
        cfg_idx_n   = 3'd0;
        launch_rd   = 1'b1;
        launch_addr = CFG_BASE;
      end

      ST_IDLE: begin
        if (reload_pend) begin
          state_n        = ST_RELOAD;
          prog_b_drive_n = 1'b1;
          cnt_n          = '0;
          reload_pend_n  = 1'b0;
        end else if (sc_frame && (sc_port == SC_PORT) && !hold_off) begin
          if (!sc_op) begin
            if (addr_hi_bad) begin
              do_ack  = 1'b1;
              ack_err = 32'd1;
            end else if (!sc_wr) begin
              kind_n      = K_READ;
              word_idx_n  = 2'd0;
              launch_rd   = 1'b1;
              launch_addr = sc_addr[ADDR_W-1:0];
            end else begin
              kind_n       = K_WRITE;
              flash_a_n    = sc_addr[ADDR_W-1:0];
              flash_dq_o_n = sc_data[DQ_W-1:0];
              flash_cs_b_n = 1'b0;
              flash_dq_t_n = 1'b0;
              flash_we_b_n = 1'b1;
              cnt_n        = '0;
              state_n      = ST_WR;
            end
          end else if (sc_subaddr == 32'd0) begin
            do_ack       = 1'b1;
            ack_reload_n = 1'b1;
          end else if (sc_subaddr == 32'd1) begin
            kind_n      = K_BOOT_SC;
            cfg_valid_n = 1'b0;
            state_n     = ST_BOOT;
          end else begin
            do_ack  = 1'b1;
            ack_err = 32'd2;
          end
        end
      end

      ST_RD: begin
        if (cnt == RD_LAST) begin
          asm_word_n[DQ_W*int'(word_idx) +: DQ_W] = flash_dq_i;
          flash_cs_b_n = 1'b1;
          flash_oe_b_n = 1'b1;
          cnt_n        = '0;
          state_n      = ST_TURN;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      // cnt 0 is the setup clock, 1..WR_CYCLES the strobe, then one hold clock.
      ST_WR: begin
        if (cnt == WR_END) begin
          flash_cs_b_n = 1'b1;
          flash_dq_t_n = 1'b1;
          cnt_n        = '0;
          state_n      = ST_TURN;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          if (cnt == '0)     flash_we_b_n = 1'b0;
          if (cnt == WR_HOLD) flash_we_b_n = 1'b1;
        end
      end

      ST_TURN: begin
        if (cnt == TURN_LAST) begin
          cnt_n = '0;
          if (kind == K_WRITE) begin
            do_ack = 1'b1;
          end else if (word_idx != LAST_WORD) begin
            word_idx_n  = word_idx + 2'd1;
            launch_rd   = 1'b1;
            launch_addr = flash_a + ADDR_W'(1);
          end else if (kind == K_READ) begin
            do_ack   = 1'b1;
            ack_data = asm_word;
          end else begin
            cfg_shadow_n = merged;
            if (cfg_idx != LAST_CFG) begin
              cfg_idx_n   = cfg_idx + 3'd1;
              word_idx_n  = 2'd0;
              launch_rd   = 1'b1;
              launch_addr = flash_a + ADDR_W'(1);
            end else begin
              // All boot reads done: publish the whole block at once.
              cfg_words_n = merged;
              cfg_valid_n = 1'b1;
              if (kind == K_BOOT_SC) begin
                do_ack   = 1'b1;
                ack_data = merged[31:0];
              end else begin
                state_n = ST_IDLE;
              end
            end
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      ST_ACK: begin
        if (ack_reload) begin
          ack_reload_n   = 1'b0;
          state_n        = ST_RELOAD;
          prog_b_drive_n = 1'b1;
          cnt_n          = '0;
          reload_pend_n  = 1'b0;
        end else begin
          // Blocks re-acceptance of a frame the requester has not dropped yet.
          hold_off_n = 1'b1;
          state_n    = ST_IDLE;
        end
      end

      ST_RELOAD: begin
        if (cnt == PROG_LAST) begin
          prog_b_drive_n = 1'b0;
          state_n        = ST_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: state_n = ST_IDLE;
    endcase

    if (launch_rd) begin
      flash_a_n    = launch_addr;
      flash_cs_b_n = 1'b0;
      flash_oe_b_n = 1'b0;
      flash_dq_t_n = 1'b1;
      cnt_n        = '0;
      state_n      = ST_RD;
    end

    if (do_ack) begin
      state_n         = ST_ACK;
      sc_ack_n        = 1'b1;
      sc_rply_data_n  = ack_data;
      sc_rply_error_n = ack_err;
    end

    // A new request edge wins over a same-cycle clear on RELOAD entry.
    if (fpga_reload && !reload_q) reload_pend_n = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_BOOT;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind          <= K_BOOT;
      cnt           <= '0;
      word_idx      <= 2'd0;
      cfg_idx       <= 3'd0;
      asm_word      <= 32'd0;
      cfg_shadow    <= '0;
      ack_reload    <= 1'b0;
      reload_q      <= 1'b0;
      reload_pend   <= 1'b0;
      hold_off      <= 1'b0;
      flash_a       <= '0;
      flash_dq_o    <= '0;
      flash_dq_t    <= 1'b1;
      flash_cs_b    <= 1'b1;
      flash_oe_b    <= 1'b1;
      flash_we_b    <= 1'b1;
      sc_ack        <= 1'b0;
      sc_rply_data  <= 32'd0;
      sc_rply_error <= 32'd0;
      cfg_words     <= '0;
      cfg_valid     <= 1'b0;
      prog_b_drive  <= 1'b0;
    end else begin
      kind          <= kind_n;
      cnt           <= cnt_n;
      word_idx      <= word_idx_n;
      cfg_idx       <= cfg_idx_n;
      asm_word      <= asm_word_n;
      cfg_shadow    <= cfg_shadow_n;
      ack_reload    <= ack_reload_n;
      reload_q      <= fpga_reload;
      reload_pend   <= reload_pend_n;
      hold_off      <= hold_off_n;
      flash_a       <= flash_a_n;
      flash_dq_o    <= flash_dq_o_n;
      flash_dq_t    <= flash_dq_t_n;
      flash_cs_b    <= flash_cs_b_n;
      flash_oe_b    <= flash_oe_b_n;
      flash_we_b    <= flash_we_b_n;
      sc_ack        <= sc_ack_n;
      sc_rply_data  <= sc_rply_data_n;
      sc_rply_error <= sc_rply_error_n;
      cfg_words     <= cfg_words_n;
      cfg_valid     <= cfg_valid_n;
      prog_b_drive  <= prog_b_drive_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flash_cfg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_flash_cfg_ctrl
// Purpose  : Directed self-checking bench for flash_cfg_ctrl with a small
//            flash read model and bus-timing monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_cfg_ctrl;

  localparam int ADDR_W  = 24;
  localparam int DQ_W    = 16;
  localparam int NUM_CFG = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  fpga_reload = 1'b0;
  logic [15:0]           sc_port = 16'h0;
  logic [31:0]           sc_data = 32'h0;
  logic [31:0]           sc_addr = 32'h0;
  logic [31:0]           sc_subaddr = 32'h0;
  logic                  sc_op = 1'b0;
  logic                  sc_wr = 1'b0;
  logic                  sc_frame = 1'b0;
  logic                  sc_ack;
  logic [31:0]           sc_rply_data, sc_rply_error;
  logic [32*NUM_CFG-1:0] cfg_words;
  logic                  cfg_valid;
  logic [ADDR_W-1:0]     flash_a;
  logic [DQ_W-1:0]       flash_dq_o, flash_dq_i;
  logic                  flash_dq_t, flash_cs_b, flash_oe_b, flash_we_b;
  logic                  prog_b_drive;

  always #5 clk = ~clk;

  flash_cfg_ctrl #(
    .ADDR_W(ADDR_W), .DQ_W(DQ_W), .NUM_CFG(NUM_CFG), .CFG_BASE(24'h7F0000),
    .RD_CYCLES(8), .WR_CYCLES(8), .TURN_CYCLES(2), .PROG_PULSE(16),
    .SC_PORT(16'h2777)
  ) dut (
    .clk(clk), .reset(reset), .fpga_reload(fpga_reload),
    .sc_port(sc_port), .sc_data(sc_data), .sc_addr(sc_addr),
    .sc_subaddr(sc_subaddr), .sc_op(sc_op), .sc_wr(sc_wr),
    .sc_frame(sc_frame), .sc_ack(sc_ack), .sc_rply_data(sc_rply_data),
    .sc_rply_error(sc_rply_error), .cfg_words(cfg_words),
    .cfg_valid(cfg_valid), .flash_a(flash_a), .flash_dq_o(flash_dq_o),
    .flash_dq_i(flash_dq_i), .flash_dq_t(flash_dq_t),
    .flash_cs_b(flash_cs_b), .flash_oe_b(flash_oe_b),
    .flash_we_b(flash_we_b), .prog_b_drive(prog_b_drive)
  );

  // Flash contents; data only driven while the chip is selected and enabled.
  function automatic logic [15:0] flash_word(input logic [23:0] a);
    case (a)
      24'h7F0000: flash_word = 16'h0A0B;
      24'h7F0001: flash_word = 16'hC0A8;
      24'h7F0002: flash_word = 16'h0001;
      24'h7F0003: flash_word = 16'h0000;
      24'h000100: flash_word = 16'h1234;
      24'h000101: flash_word = 16'hABCD;
      default:    flash_word = 16'h5A5A;
    endcase
  endfunction

  assign flash_dq_i = (!flash_cs_b && !flash_oe_b) ? flash_word(flash_a) : 16'hFFFF;

  // Bus monitors, sampled on the falling edge.
  int oe_run = 0, oe_windows = 0, oe_min = 1000, oe_max = 0;
  int we_run = 0, we_last = 0, we_bad = 0;
  int prog_run = 0, prog_last = 0, prog_pulses = 0;
  int ack_cnt = 0, cs_low = 0;
  logic [23:0] exp_wa = 24'h0;
  logic [15:0] exp_wd = 16'h0;

  always @(negedge clk) begin
    if (!flash_oe_b) oe_run++;
    else if (oe_run != 0) begin
      oe_windows++;
      if (oe_run < oe_min) oe_min = oe_run;
      if (oe_run > oe_max) oe_max = oe_run;
      oe_run = 0;
    end
    if (!flash_we_b) begin
      we_run++;
      if (flash_a !== exp_wa || flash_dq_o !== exp_wd || flash_dq_t !== 1'b0 ||
          flash_oe_b !== 1'b1 || flash_cs_b !== 1'b0) we_bad++;
    end else if (we_run != 0) begin
      we_last = we_run;
      we_run  = 0;
    end
    if (prog_b_drive) prog_run++;
    else if (prog_run != 0) begin
      prog_last = prog_run;
      prog_pulses++;
      prog_run = 0;
    end
    if (sc_ack) ack_cnt++;
    if (!flash_cs_b) cs_low++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SC transaction; frame is dropped as soon as the ack is seen.
  task automatic sc_req(input logic op, input logic wr, input logic [15:0] port,
                        input logic [31:0] addr, input logic [31:0] sub,
                        input logic [31:0] data, input int max_cyc,
                        output logic got, output int cyc,
                        output logic [31:0] rdata, output logic [31:0] rerr);
    sc_op = op; sc_wr = wr; sc_port = port; sc_addr = addr;
    sc_subaddr = sub; sc_data = data; sc_frame = 1'b1;
    got = 1'b0; cyc = 0; rdata = 32'h0; rerr = 32'h0;
    while (!got && cyc < max_cyc) begin
      tick(1);
      cyc++;
      if (sc_ack) begin
        got   = 1'b1;
        rdata = sc_rply_data;
        rerr  = sc_rply_error;
      end
    end
    sc_frame = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        got;
    int          cyc, a0, c0, o0, b0, p0;
    logic [31:0] rd, re;

    // Reset state
    tick(2);
    check("reset_ctl", {flash_cs_b, flash_oe_b, flash_we_b, flash_dq_t,
                        cfg_valid, sc_ack, prog_b_drive}, 7'b1111000);
    check("reset_bus", {flash_a, flash_dq_o}, 40'h0);
    check("reset_words", cfg_words, 64'h0);

    // Boot: 4 bus reads of 8 + 2 clocks, plus the launch clock
    reset = 1'b0;
    cyc = 0;
    while (!cfg_valid && cyc < 200) begin tick(1); cyc++; end
    check("boot_valid", cfg_valid, 1'b1);
    check("boot_latency_40_41", (cyc >= 40 && cyc <= 41), 1'b1);
    check("boot_words", cfg_words, 64'h00000001_C0A80A0B);
    check("boot_oe_windows", oe_windows, 4);
    check("boot_oe_min", oe_min, 8);
    check("boot_oe_max", oe_max, 8);

    // 32-bit SC read, little-endian assembly
    tick(2);
    a0 = ack_cnt; o0 = oe_windows;
    sc_req(1'b0, 1'b0, 16'h2777, 32'h100, 32'h0, 32'h0, 100, got, cyc, rd, re);
    check("rd_ack", got, 1'b1);
    check("rd_data", rd, 32'hABCD1234);
    check("rd_err", re, 32'h0);
    tick(5);
    check("rd_single_ack", ack_cnt - a0, 1);
    check("rd_bus_reads", oe_windows - o0, 2);

    // Frame on a foreign port is ignored
    a0 = ack_cnt; c0 = cs_low;
    sc_port = 16'h2776; sc_op = 1'b0; sc_wr = 1'b0; sc_addr = 32'h100; sc_frame = 1'b1;
    tick(40);
    sc_frame = 1'b0;
    tick(2);
    check("wp_no_ack", ack_cnt - a0, 0);
    check("wp_no_bus", cs_low - c0, 0);

    // Single bus write
    exp_wa = 24'h55; exp_wd = 16'hAA;
    b0 = we_bad; o0 = oe_windows;
    sc_req(1'b0, 1'b1, 16'h2777, 32'h55, 32'h0, 32'h000000AA, 100, got, cyc, rd, re);
    check("wr_ack", got, 1'b1);
    check("wr_err", re, 32'h0);
    check("wr_we_len", we_last, 8);
    check("wr_we_window_stable", we_bad - b0, 0);
    check("wr_no_oe", oe_windows - o0, 0);
    tick(3);

    // Address above ADDR_W: immediate error, no bus cycle
    c0 = cs_low;
    sc_req(1'b0, 1'b0, 16'h2777, 32'h01000000, 32'h0, 32'h0, 10, got, cyc, rd, re);
    check("aerr_ack", got, 1'b1);
    check("aerr_latency", cyc, 1);
    check("aerr_code", re, 32'h1);
    tick(3);
    check("aerr_no_bus", cs_low - c0, 0);

    // Unknown control subaddress
    sc_req(1'b1, 1'b0, 16'h2777, 32'h0, 32'h5, 32'h0, 10, got, cyc, rd, re);
    check("sub5_ack", got, 1'b1);
    check("sub5_latency", cyc, 1);
    check("sub5_code", re, 32'h2);
    tick(3);

    // Boot re-run via control subaddress 1
    sc_req(1'b1, 1'b0, 16'h2777, 32'h0, 32'h1, 32'h0, 100, got, cyc, rd, re);
    check("reboot_ack", got, 1'b1);
    check("reboot_data", rd, 32'hC0A80A0B);
    check("reboot_err", re, 32'h0);
    check("reboot_valid", cfg_valid, 1'b1);
    tick(3);

    // Reload edge during a read: read finishes and acks first
    p0 = prog_pulses;
    fork
      sc_req(1'b0, 1'b0, 16'h2777, 32'h100, 32'h0, 32'h0, 100, got, cyc, rd, re);
      begin
        tick(5);
        fpga_reload = 1'b1;
        tick(1);
        fpga_reload = 1'b0;
      end
    join
    check("rl_rd_ack", got, 1'b1);
    check("rl_rd_data", rd, 32'hABCD1234);
    check("rl_no_pulse_before_ack", (prog_pulses - p0) + prog_run + int'(prog_b_drive), 0);
    cyc = 0;
    while (prog_pulses == p0 && cyc < 60) begin tick(1); cyc++; end
    check("rl_pulse_count", prog_pulses - p0, 1);
    check("rl_pulse_len", prog_last, 16);
    tick(3);

    // Reload via control subaddress 0: ack, then pulse
    p0 = prog_pulses;
    sc_req(1'b1, 1'b0, 16'h2777, 32'h0, 32'h0, 32'h0, 10, got, cyc, rd, re);
    check("rc_ack", got, 1'b1);
    check("rc_err", re, 32'h0);
    check("rc_prog_low_at_ack", prog_b_drive, 1'b0);
    cyc = 0;
    while (prog_pulses == p0 && cyc < 60) begin tick(1); cyc++; end
    check("rc_pulse_count", prog_pulses - p0, 1);
    check("rc_pulse_len", prog_last, 16);
    tick(3);

    // Reset asserted while WE_B is low
    a0 = ack_cnt;
    exp_wa = 24'h66; exp_wd = 16'h33;
    sc_port = 16'h2777; sc_op = 1'b0; sc_wr = 1'b1; sc_addr = 32'h66;
    sc_data = 32'h33; sc_frame = 1'b1;
    cyc = 0;
    while (flash_we_b && cyc < 20) begin tick(1); cyc++; end
    check("mr_we_low_seen", flash_we_b, 1'b0);
    tick(3);
    #2 reset = 1'b1;
    #1;
    check("mr_bus_released", {flash_cs_b, flash_we_b, flash_oe_b, flash_dq_t}, 4'b1111);
    sc_frame = 1'b0;
    tick(3);
    check("mr_no_ack", ack_cnt - a0, 0);
    check("mr_cfg_cleared", {cfg_valid, cfg_words}, 65'h0);
    reset = 1'b0;
    cyc = 0;
    while (!cfg_valid && cyc < 200) begin tick(1); cyc++; end
    check("mr_reboot_valid", cfg_valid, 1'b1);
    check("mr_reboot_words", cfg_words, 64'h00000001_C0A80A0B);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/flash_cfg_ctrl.md
Name: flash_cfg_ctrl

Overview:
- Parametrised parallel-NOR flash controller for the SRU.
- After reset it reads a block of configuration words from flash, such as the SRU IP address and board options, and presents them as static outputs.
- It then serves slow-control (SC) flash read/write and control requests, including FPGA reload by pulsing PROG_B, with programmable bus timing.
- It sits between the SC dispatcher and the top-level flash IOBUFs.

Parameters:
- ADDR_W, 24: flash word-address width.
- DQ_W, 16: flash data width; legal values 8, 16, 32. NB = 32/DQ_W bus words form one 32-bit word.
- NUM_CFG, 2: number of 32-bit config words read at boot (1..8).
- CFG_BASE, 24'h7F0000: flash word address of config word 0.
- RD_CYCLES, 8: clocks that CS_B/OE_B are held low per read; minimum 2.
- WR_CYCLES, 8: clocks that WE_B is held low per write; minimum 1.
- TURN_CYCLES, 2: idle clocks with CS_B high after every bus cycle.
- PROG_PULSE, 16: clocks prog_b_drive is held high on reload.
- SC_PORT, 16'h2777: SC port served by this block.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fpga_reload  in  1  synchronous reload request; rising edge is the trigger
- sc_port  in  16  SC destination port
- sc_data  in  32  SC write data
- sc_addr  in  32  SC flash word address
- sc_subaddr  in  32  SC control selector
- sc_op  in  1  0 = flash access, 1 = control
- sc_wr  in  1  1 = write, 0 = read
- sc_frame  in  1  request; held high by requester until sc_ack
- sc_ack  out  1  one-cycle completion pulse
- sc_rply_data  out  32  reply data, valid with sc_ack
- sc_rply_error  out  32  reply status, valid with sc_ack
- cfg_words  out  32*NUM_CFG  config words; word i at bits [32i+31:32i]
- cfg_valid  out  1  cfg_words complete
- flash_a  out  ADDR_W  flash address
- flash_dq_o  out  DQ_W  flash write data
- flash_dq_i  in  DQ_W  flash read data
- flash_dq_t  out  1  1 = tristate (read), 0 = drive
- flash_cs_b  out  1  chip select, active low
- flash_oe_b  out  1  output enable, active low
- flash_we_b  out  1  write enable, active low
- prog_b_drive  out  1  1 = drive FPGA_PROG_B low

Behaviour:

Reset values:
- cs_b, oe_b, we_b, dq_t = 1.
- flash_a, dq_o, sc_ack, sc_rply_data, sc_rply_error, cfg_words, cfg_valid, prog_b_drive = 0.
- State = BOOT. Boot starts on the first clock after reset deasserts.

States: BOOT, IDLE, RD, WR, TURN, ACK, RELOAD.

Read bus cycle:
- flash_a, cs_b = 0, oe_b = 0 and dq_t = 1 are set together and held RD_CYCLES clocks.
- flash_dq_i is registered on the last clock of that window.
- cs_b and oe_b then rise, followed by TURN_CYCLES idle clocks.

Write bus cycle:
- Clock 1 (setup): flash_a, dq_o, cs_b = 0, dq_t = 0.
- Next WR_CYCLES clocks: we_b = 0.
- Next 1 clock (hold): we_b = 1.
- Then cs_b = 1 and dq_t = 1, followed by TURN.
- oe_b stays 1 throughout.

32-bit assembly:
- A 32-bit read is NB consecutive bus reads at A, A+1, ..., little-endian; the read at A supplies bits [DQ_W-1:0].
- Address arithmetic is ADDR_W-bit and wraps modulo 2^ADDR_W.

BOOT:
- Reads NUM_CFG × NB bus words starting at CFG_BASE.
- cfg_words is updated only after all reads complete; cfg_valid rises the same cycle.
- SC requests are not accepted during BOOT.

IDLE accepts sc_frame = 1 with sc_port == SC_PORT. Frames to other ports are ignored with no ack. Decoding:
- op=0, wr=0: 32-bit read at sc_addr; rply_data = assembled word.
- op=0, wr=1: single bus write of sc_data[DQ_W-1:0] to sc_addr. Command sequences are issued by software as separate writes.
- op=0 with sc_addr[31:ADDR_W] != 0: no bus cycle; error = 1.
- op=1, subaddr 0: reload. Ack first; RELOAD starts the next cycle.
- op=1, subaddr 1: re-run boot. cfg_valid drops, BOOT runs, then ack with rply_data = cfg word 0.
- op=1, other subaddr: error = 2, no side effect.

Ack timing:
- Error acks occur 1 clock after acceptance.
- Successful accesses ack after the final TURN completes.
- sc_ack is high for exactly 1 cycle, and rply_error = 0 on success.
- The next frame is accepted no earlier than 1 cycle after sc_ack. A still-high sc_frame in that cycle is not re-accepted.

Reload:
- A rising edge on fpga_reload sets a pending flag, in any state.
- Pending is serviced on entry to IDLE and has priority over a simultaneous sc_frame.
- RELOAD: prog_b_drive = 1 for exactly PROG_PULSE clocks, then 0, then return to IDLE.
- The pending flag clears when RELOAD is entered.

Reset mid-operation:
- Reset forces all outputs to reset values immediately: bus released, pulse aborted, no ack.
- Boot reruns after reset deasserts.

Test Plan:
- Boot (DQ_W=16, NUM_CFG=2): flash model holds 0x0A0B, 0xC0A8, 0x0001, 0x0000 at 7F0000..7F0003 -> cfg_words = {32'h00000001, 32'hC0A80A0B}. cfg_valid rises after 4×(8+2) clocks. Each OE_B low window is exactly 8 clocks.
- SC read port 0x2777, addr 0x000100, flash 0x1234@100 and 0xABCD@101 -> single sc_ack with rply_data = 32'hABCD1234 and error 0. A frame on port 0x2776 -> no ack, no bus activity.
- SC write addr 0x000055, data 0x000000AA -> dq_t low, WE_B low exactly 8 clocks with addr=0x55 and dq_o=0xAA stable across the window. OE_B stays high; then ack.
- sc_addr = 0x01000000 -> ack after 1 clock with error = 1 and CS_B never low. op=1, subaddr 5 -> error = 2.
- fpga_reload edge during an SC read -> read completes and acks first; then prog_b_drive is high for exactly 16 clocks. op=1 subaddr 0 -> ack, then the same pulse.
- Reset asserted mid write (WE_B low) -> WE_B and CS_B go to 1 asynchronously, no ack. After release, boot reruns and cfg_valid returns.
